// File: rtl/pulse_transmitter_sequencer_if.sv
// Bus bundle for the pulse transmitter sequencer: start/stop control,
// symbol table write port, per-run configuration and the transmitter outputs.
interface pulse_transmitter_sequencer_if #(
  parameter int DEPTH = 8
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          start_i;
  logic          stop_i;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [8:0]    wr_data;          // [8] = level, [7:0] = duration
  logic [3:0]    cfg_num_symbols;
  logic [7:0]    cfg_loop_count;
  logic [3:0]    cfg_prescale;
  logic          pulse_out;
  logic          busy_o;
  logic          done_o;

  // Controller side: drives requests and configuration, observes the outputs.
  modport master (
    output start_i, stop_i, wr_en, wr_addr, wr_data,
           cfg_num_symbols, cfg_loop_count, cfg_prescale,
    input  pulse_out, busy_o, done_o
  );

  // Sequencer side.
  modport slave (
    input  start_i, stop_i, wr_en, wr_addr, wr_data,
           cfg_num_symbols, cfg_loop_count, cfg_prescale,
    output pulse_out, busy_o, done_o
  );
endinterface

// File: rtl/pulse_transmitter_sequencer.sv
// Pulse transmitter sequencer: plays a table of {level, duration} symbols,
// each lasting (dur+1)*(prescale+1) cycles, for cfg_loop_count+1 passes.
// The interface DEPTH parameter must match the one given here, and DEPTH
// must stay <= 15 so the clamped symbol count fits the 4-bit config field.
module pulse_transmitter_sequencer #(
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   DEPTH      = 8
) (
  input logic                          clk,
  input logic                          rst_n,
  pulse_transmitter_sequencer_if.slave bus
);
  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_N = 4'(DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Symbol table is held in flops so the next symbol's level and duration
  // are readable in the same cycle as a symbol boundary; this keeps symbols
  // and passes back to back with no gap cycles.
  logic [8:0] sym_mem [DEPTH];

  logic [0:0]    state_q, state_d;
  logic          start_q;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    pass_q, pass_d;
  logic [3:0]    num_q, num_d;
  logic [3:0]    ps_cap_q, ps_cap_d;
  logic [3:0]    ps_q, ps_d;
  logic [7:0]    dur_q, dur_d;
  logic          pulse_q, pulse_d;
  logic          done_q, done_d;

  logic          start_edge;
  logic [3:0]    num_clamped;
  logic [8:0]    cur_sym;
  logic [AW-1:0] idx_inc;
  logic          tick;
  logic          sym_end;
  logic          last_sym;

  assign start_edge  = bus.start_i && !start_q;
  assign num_clamped = (bus.cfg_num_symbols > DEPTH_N) ? DEPTH_N : bus.cfg_num_symbols;
  assign cur_sym     = sym_mem[idx_q];
  assign idx_inc     = idx_q + AW'(1);
  assign tick        = (ps_q == ps_cap_q);
  assign sym_end     = tick && (dur_q == cur_sym[7:0]);
  assign last_sym    = ((4'(idx_q) + 4'd1) == num_q);

  // Table writes are accepted only while idle; contents survive reset and stop.
  always_ff @(posedge clk) begin
    if (bus.wr_en && (state_q == S_IDLE)) begin
      sym_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Next-state logic: start capture, prescale/duration counting, symbol stepping.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pass_d   = pass_q;
    num_d    = num_q;
    ps_cap_d = ps_cap_q;
    ps_d     = ps_q;
    dur_d    = dur_q;
    pulse_d  = pulse_q;
    done_d   = 1'b0;

    if (bus.stop_i) begin
      // Abort wins over everything, including a simultaneous start edge.
      state_d = S_IDLE;
      pulse_d = IDLE_LEVEL;
      idx_d   = '0;
      ps_d    = '0;
      dur_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pulse_d = IDLE_LEVEL;
          if (start_edge && (num_clamped != 4'd0)) begin
            state_d  = S_RUN;
            idx_d    = '0;
            pass_d   = bus.cfg_loop_count;
            num_d    = num_clamped;
            ps_cap_d = bus.cfg_prescale;
            ps_d     = '0;
            dur_d    = '0;
            pulse_d  = sym_mem[0][8];
          end
        end
        S_RUN: begin
          ps_d = tick ? 4'd0 : ps_q + 4'd1;
          if (tick) begin
            if (sym_end) begin
              dur_d = '0;
              if (!last_sym) begin
                idx_d   = idx_inc;
                pulse_d = sym_mem[idx_inc][8];
              end else if (pass_q != 8'd0) begin
                pass_d  = pass_q - 8'd1;
                idx_d   = '0;
                pulse_d = sym_mem[0][8];
              end else begin
                state_d = S_IDLE;
                idx_d   = '0;
                pulse_d = IDLE_LEVEL;
                done_d  = 1'b1;
              end
            end else begin
              dur_d = dur_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          pulse_d = IDLE_LEVEL;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      idx_q    <= '0;
      pass_q   <= '0;
      num_q    <= '0;
      ps_cap_q <= '0;
      ps_q     <= '0;
      dur_q    <= '0;
      pulse_q  <= IDLE_LEVEL;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= bus.start_i;
      idx_q    <= idx_d;
      pass_q   <= pass_d;
      num_q    <= num_d;
      ps_cap_q <= ps_cap_d;
      ps_q     <= ps_d;
      dur_q    <= dur_d;
      pulse_q  <= pulse_d;
      done_q   <= done_d;
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.busy_o    = (state_q == S_RUN);
  assign bus.done_o    = done_q;
endmodule

// File: doc/pulse_transmitter_sequencer.md
PULSE_TRANSMITTER_SEQUENCER -- requirements
Module: pulse_transmitter_sequencer

Interface
REQ-001 Parameter IDLE_LEVEL, default 1'b0: pulse_out level whenever not running.
REQ-002 Parameter DEPTH, default 8: symbol table entries; address width 3 bits at default.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start_i  input  1  level request; a 0->1 transition sampled on clk starts a sequence.
REQ-006 stop_i  input  1  synchronous abort, level-sensitive.
REQ-007 wr_en  input  1  symbol table write strobe.
REQ-008 wr_addr  input  3  symbol table write index.
REQ-009 wr_data  input  9  symbol: bit 8 = level, bits 7:0 = duration dur.
REQ-010 cfg_num_symbols  input  4  symbols per pass; 0 = start ignored; values >DEPTH clamp to DEPTH.
REQ-011 cfg_loop_count  input  8  extra passes; total passes = cfg_loop_count+1.
REQ-012 cfg_prescale  input  4  tick divider; one tick every cfg_prescale+1 cycles.
REQ-013 pulse_out  output  1  registered transmitter output.
REQ-014 busy_o  output  1  high while in RUN.
REQ-015 done_o  output  1  one-cycle pulse on normal completion.

Function
REQ-016 Two states SHALL exist: IDLE and RUN.
REQ-017 Start edge SHALL be detected internally: edge = start_i && !start_q, start_q registered each cycle.
REQ-018 In IDLE, an edge with clamped cfg_num_symbols >= 1 and stop_i=0 SHALL enter RUN on the next edge with idx=0, pass counter = cfg_loop_count, prescale and duration counters loaded for symbol 0.
REQ-019 cfg_num_symbols, cfg_loop_count, cfg_prescale SHALL be captured at start; changes during RUN SHALL have no effect.
REQ-020 Start edges during RUN SHALL be ignored (not queued).
REQ-021 In RUN, pulse_out SHALL equal the level bit of symbol idx, registered, valid from the first RUN cycle.
REQ-022 Tick SHALL assert when the prescale counter equals captured prescale; counter then wraps to 0.
REQ-023 Each symbol SHALL last exactly (dur+1)*(prescale+1) cycles; dur=0 gives prescale+1 cycles.
REQ-024 At symbol end: if idx < num-1, idx increments; else if pass counter > 0, decrement it and idx=0; else enter IDLE.
REQ-025 On normal exit to IDLE, done_o SHALL be 1 for exactly the first IDLE cycle; busy_o=0 and pulse_out=IDLE_LEVEL that same cycle.
REQ-026 Sequence length SHALL be (loop+1) * sum over symbols of (dur+1)*(prescale+1) cycles, with no gap cycles between symbols or passes.
REQ-027 stop_i=1 in any state SHALL force IDLE next cycle, pulse_out=IDLE_LEVEL, done_o=0; stop_i with start edge in the same cycle: stop wins.
REQ-028 Symbol table writes SHALL occur only when wr_en=1 and state is IDLE; writes during RUN SHALL be dropped.
REQ-029 Table contents SHALL NOT be cleared by reset or stop.

Reset
REQ-030 rst_n=0 SHALL set state IDLE, pulse_out=IDLE_LEVEL, busy_o=0, done_o=0, start_q=0, all counters 0.
REQ-031 start_i already high when rst_n releases SHALL count as an edge on the first post-reset cycle.
REQ-032 Reset asserted mid-RUN SHALL abort without done_o.

Verification
REQ-033 Table {1/dur2, 0/dur0}, num=2, loop=0, prescale=0, start edge at cycle N -> pulse_out 1 for N+1..N+3, 0 at N+4, done_o=1 and busy_o=0 at N+5.
REQ-034 Same table, prescale=1, loop=1 -> 1 for 6 cycles, 0 for 2, repeated twice, total busy 16 cycles, single done_o.
REQ-035 stop_i pulsed 3 cycles into RUN -> busy_o=0, pulse_out=IDLE_LEVEL next cycle, done_o never asserts.
REQ-036 cfg_num_symbols=0 with start edge -> stays IDLE, busy_o=0; cfg_num_symbols=12 -> exactly 8 symbols played.
REQ-037 Start toggled and wr_en pulsed with new data during RUN -> no restart, output matches original table; write absent afterward.
REQ-038 start_i held high through reset release -> RUN entered on second cycle after rst_n rises.
